inst_enc: RTL and testbench

Sequential RV32I instruction encoder and program writer: accepts decoded instruction fields (opcode, registers, funct, full-width immediate) over a valid/ready handshake, packs them into a 32-bit instruction word by format, range-checks the immediate, and writes the word into instruction memory at an auto-incrementing address. It is the inverse of the instruction decode stage and is used as an on-FPGA program loader and as a stimulus source for decode/execute benches.

---
 rtl/inst_enc_pkg.sv | 59 +++++
 rtl/inst_enc_pack.sv | 52 +++++
 rtl/inst_enc.sv | 120 ++++++++++++
 tb/tb_inst_enc.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_enc_pkg.sv
// Shared RV32I encoder definitions: major opcodes (inst[6:2]), instruction formats,
// FSM state encoding and the decoded-field payload.
package inst_enc_pkg;

    localparam int unsigned RFW = 5;
    localparam int unsigned DW  = 32;
    localparam int unsigned IW  = 32;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [2:0] FMT_X = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENC   = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    typedef struct packed {
        logic [4:0]     opcode;
        logic [2:0]     funct3;
        logic [6:0]     funct7;
        logic [RFW-1:0] rd;
        logic [RFW-1:0] rs1;
        logic [RFW-1:0] rs2;
        logic [DW-1:0]  imm;
    } inst_fields_t;

    // Map a major opcode to its instruction format; FMT_X marks an unsupported opcode.
    function automatic logic [2:0] fmt_of(input logic [4:0] op);
        logic [2:0] f;
        case (op)
            OPC_OP:                                       f = FMT_R;
            OPC_OP_IMM, OPC_JALR, OPC_LOAD, OPC_SYSTEM:  f = FMT_I;
            OPC_STORE:                                    f = FMT_S;
            OPC_BRANCH:                                   f = FMT_B;
            OPC_LUI, OPC_AUIPC:                           f = FMT_U;
            OPC_JAL:                                      f = FMT_J;
            default:                                      f = FMT_X;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/inst_enc_pack.sv
// Combinational RV32I field packer: builds the 32-bit word by format and flags
// immediates that cannot be represented.
module inst_pack
    import inst_enc_pkg::*;
(
    input  inst_fields_t   fields,
    output logic [IW-1:0]  word,
    output logic           illegal
);

    logic [2:0]           fmt;
    logic [DW-1:0]        imm;
    logic signed [DW-1:0] simm;

    always_comb begin
        fmt     = fmt_of(fields.opcode);
        imm     = fields.imm;
        simm    = $signed(fields.imm);
        word    = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_R: word = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                           fields.rd, fields.opcode, 2'b11};
            FMT_I: begin
                word    = {imm[11:0], fields.rs1, fields.funct3, fields.rd,
                           fields.opcode, 2'b11};
                illegal = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            FMT_S: begin
                word    = {imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                           imm[4:0], fields.opcode, 2'b11};
                illegal = (simm < -32'sd2048) || (simm > 32'sd2047);
            end
            FMT_B: begin
                word    = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                           imm[4:1], imm[11], fields.opcode, 2'b11};
                illegal = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
            end
            FMT_U: begin
                word    = {imm[31:12], fields.rd, fields.opcode, 2'b11};
                illegal = (imm[11:0] != 12'd0);
            end
            FMT_J: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd,
                           fields.opcode, 2'b11};
                illegal = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_enc.sv
// RV32I instruction encoder / program writer: accepts field tuples, packs them and
// writes each legal word to instruction memory at an auto-incrementing address.
module inst_enc
    import inst_enc_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [RFW-1:0]    rd,
    input  logic [RFW-1:0]    rs1,
    input  logic [RFW-1:0]    rs2,
    input  logic [DW-1:0]     imm,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [IW-1:0]     mem_wdata,
    input  logic              mem_ack,
    output logic              err,
    output logic              ovf,
    output logic [AW:0]       count
);

    localparam int unsigned CW = AW + 1;

    state_e       state;
    state_e       state_nxt;
    inst_fields_t fields_q;
    logic [IW-1:0] word;
    logic         illegal;

    logic start_load;
    logic accept;
    logic enc_ok;
    logic enc_bad;
    logic write_done;

    inst_pack u_pack (
        .fields  (fields_q),
        .word    (word),
        .illegal (illegal)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!start && in_valid) state_nxt = ST_ENC;
            ST_ENC:   state_nxt = illegal ? ST_IDLE : ST_WRITE;
            ST_WRITE: if (mem_ack) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs; start takes priority over an offered tuple in IDLE
    always_comb begin
        in_ready   = 1'b0;
        start_load = 1'b0;
        enc_ok     = 1'b0;
        enc_bad    = 1'b0;
        write_done = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready   = !start && !rst;
                start_load = start;
            end
            ST_ENC: begin
                enc_ok  = !illegal;
                enc_bad = illegal;
            end
            ST_WRITE: write_done = mem_ack;
            default: ;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Datapath: field capture, word register, write address and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            fields_q  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            count     <= '0;
        end else begin
            err    <= enc_bad;
            mem_we <= (state_nxt == ST_WRITE);
            if (accept) begin
                fields_q <= '{opcode: opcode, funct3: funct3, funct7: funct7,
                              rd: rd, rs1: rs1, rs2: rs2, imm: imm};
            end
            if (enc_ok) mem_wdata <= word;
            if (start_load) begin
                mem_addr <= base_addr;
                count    <= '0;
                ovf      <= 1'b0;
            end else if (write_done) begin
                mem_addr <= mem_addr + AW'(1);
                count    <= count + CW'(1);
                if (&mem_addr) ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_enc.sv
// Scoreboard bench for inst_enc: expected writes/errors are queued at issue time
// and matched by an independent monitor on the memory and err outputs.
module tb_inst_enc;

    localparam int unsigned AW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [AW-1:0]  base_addr;
    logic           in_valid;
    logic           in_ready;
    logic [4:0]     opcode;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    logic [4:0]     rd, rs1, rs2;
    logic [31:0]    imm;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [31:0]    mem_wdata;
    logic           mem_ack;
    logic           err;
    logic           ovf;
    logic [AW:0]    count;

    typedef struct {
        bit          is_err;
        logic [AW-1:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   stall  = 0;
    int   stall_seen = 0;

    inst_enc #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .err(err), .ovf(ovf), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic push_w(input logic [AW-1:0] a, input logic [31:0] d);
        exp_t e;
        e.is_err = 1'b0; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_e();
        exp_t e;
        e.is_err = 1'b1; e.addr = '0; e.data = '0;
        exp_q.push_back(e);
    endtask

    // Memory responder: acks the write the cycle it appears unless a stall is pending
    always @(posedge clk) begin
        #1;
        if (mem_we && stall > 0) begin
            mem_ack = 1'b0;
            stall--;
        end else begin
            mem_ack = mem_we;
        end
    end

    // Monitor: consume one expected event per err pulse or acknowledged write
    always @(negedge clk) begin
        if (!rst) begin
            if (err) begin
                if (exp_q.size() == 0) chk("unexpected_err", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("err_expected", 32'(err), 32'(e.is_err));
                end
            end
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    if (mem_ack) chk("unexpected_write", 32'd1, 32'd0);
                end else if (mem_ack) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("write_is_not_err", 32'(e.is_err), 32'd0);
                    chk("write_addr", 32'(mem_addr), 32'(e.addr));
                    chk("write_data", mem_wdata, e.data);
                end else begin
                    stall_seen++;
                    chk("stall_addr_stable", 32'(mem_addr), 32'(exp_q[0].addr));
                    chk("stall_data_stable", mem_wdata, exp_q[0].data);
                end
            end
        end
    end

    task automatic send(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
        end
        if (!got) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
        end
        if (!got) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b;
        @(negedge clk);
        chk("ready_low_on_start", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; mem_ack = 1'b0;
        opcode = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // addi x1, x0, 5
        do_start(2'd0);
        push_w(2'd0, 32'h00500093);
        send(5'b00100, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        wait_idle();
        chk("count_after_addi", 32'(count), 32'd1);
        chk("addr_after_addi", 32'(mem_addr), 32'd1);

        // sw x2, 8(x1) then beq x1, x2, -4 back to back
        push_w(2'd1, 32'h0020A423);
        push_w(2'd2, 32'hFE208EE3);
        send(5'b01000, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        send(5'b11000, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        wait_idle();
        chk("count_after_sb", 32'(count), 32'd3);
        chk("ovf_no_wrap", 32'(ovf), 32'd0);

        // jal x1, 2048 and lui x5, 0x12345
        do_start(2'd0);
        chk("count_cleared_by_start", 32'(count), 32'd0);
        push_w(2'd0, 32'h001000EF);
        push_w(2'd1, 32'h123452B7);
        send(5'b11011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        send(5'b01101, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        wait_idle();
        chk("count_after_ju", 32'(count), 32'd2);

        // Rejected tuples: I imm 2048, odd branch offset, LUI low bits, unknown opcode
        push_e(); push_e(); push_e(); push_e();
        send(5'b00100, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        send(5'b11000, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        send(5'b01101, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345001);
        send(5'b11111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("count_after_errs", 32'(count), 32'd2);
        chk("addr_after_errs", 32'(mem_addr), 32'd2);
        chk("wdata_kept_after_errs", mem_wdata, 32'h123452B7);

        // I-type lower bound is legal: addi x1, x0, -2048
        push_w(2'd2, 32'h80000093);
        send(5'b00100, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800);
        wait_idle();
        chk("count_after_min_imm", 32'(count), 32'd3);

        // Wrap: base 3, first write stalled 4 cycles, then sub/auipc
        do_start(2'd3);
        chk("ovf_cleared_by_start", 32'(ovf), 32'd0);
        stall = 4; stall_seen = 0;
        push_w(2'd3, 32'h402081B3);
        send(5'b01100, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0);
        wait_idle();
        chk("stall_cycles", 32'(stall_seen), 32'd4);
        chk("ovf_after_wrap", 32'(ovf), 32'd1);
        chk("addr_wrapped", 32'(mem_addr), 32'd0);
        push_w(2'd0, 32'hFFFFF117);
        send(5'b00101, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'hFFFF_F000);
        wait_idle();
        chk("count_after_wrap", 32'(count), 32'd2);
        chk("addr_after_wrap", 32'(mem_addr), 32'd1);
        chk("ovf_sticky", 32'(ovf), 32'd1);

        // Reset during a stalled write aborts it
        stall = 100;
        send(5'b11100, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (mem_we) begin got = 1'b1; break; end
            end
            if (!got) chk("write_start_timeout", 32'd0, 32'd1);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_count", 32'(count), 32'd0);
        chk("abort_in_ready_in_rst", 32'(in_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0; stall = 0;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_ovf", 32'(ovf), 32'd0);
        chk("abort_addr", 32'(mem_addr), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_still_idle_we", 32'(mem_we), 32'd0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
